// File: rtl/axi4_accel_regbank.sv
// axi4_accel_regbank: AXI4-lite register bank fronting a hash core (message, control/status, digest, watchdog, irq).
module axi4_accel_regbank #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int MSG_WORDS = 16,
  parameter int DIGEST_WORDS = 8,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mem_axi_awvalid,
  output logic                      mem_axi_awready,
  input  logic [31:0]               mem_axi_awaddr,
  input  logic                      mem_axi_wvalid,
  output logic                      mem_axi_wready,
  input  logic [31:0]               mem_axi_wdata,
  input  logic [3:0]                mem_axi_wstrb,
  output logic                      mem_axi_bvalid,
  input  logic                      mem_axi_bready,
  output logic [1:0]                mem_axi_bresp,
  input  logic                      mem_axi_arvalid,
  output logic                      mem_axi_arready,
  input  logic [31:0]               mem_axi_araddr,
  output logic                      mem_axi_rvalid,
  input  logic                      mem_axi_rready,
  output logic [31:0]               mem_axi_rdata,
  output logic [1:0]                mem_axi_rresp,
  output logic [MSG_WORDS*32-1:0]   msg_o,
  output logic                      core_rst_o,
  input  logic                      core_ready_i,
  input  logic [DIGEST_WORDS*32-1:0] digest_i,
  output logic                      irq_o
);
  localparam int MW = MSG_WORDS > 1 ? $clog2(MSG_WORDS) : 1;
  localparam int DW = DIGEST_WORDS > 1 ? $clog2(DIGEST_WORDS) : 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYC - 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic aw_full, w_full, irq_en, auto_mode, done, err, done_set, err_set;
  logic [31:0] aw_addr, w_data, wd, rd_val;
  logic [3:0] w_strb;
  logic [31:0] msg [MSG_WORDS];
  logic [31:0] dig [DIGEST_WORDS];
  logic wr_go, wr_ctrl, wr_stat, wr_msg, wr_ok, start_req;
  logic rd_ctrl, rd_stat, rd_dig, rd_msg, rd_ok;
  logic w_hit, r_hit;
  logic [5:0] w_idx, r_idx;
  assign w_hit = aw_addr[31:12] == BASE_ADDR[31:12] && aw_addr[1:0] == 2'b00;
  assign r_hit = mem_axi_araddr[31:12] == BASE_ADDR[31:12] && mem_axi_araddr[1:0] == 2'b00;
  assign w_idx = aw_addr[7:2];
  assign r_idx = mem_axi_araddr[7:2];
  assign wr_go = aw_full & w_full & ~mem_axi_bvalid;
  assign wr_ctrl = w_hit && aw_addr[11:0] == 12'h000;
  assign wr_stat = w_hit && aw_addr[11:0] == 12'h004;
  assign wr_msg = w_hit && aw_addr[11:8] == 4'h3 && int'(w_idx) < MSG_WORDS;
  assign wr_ok = wr_ctrl | wr_stat | (wr_msg & state == IDLE);
  // AUTO launches the core on the last message word, so software can skip the START write
  assign start_req = wr_go & ((wr_ctrl & w_strb[0] & w_data[0]) |
                              (wr_msg & state == IDLE & auto_mode & int'(w_idx) == MSG_WORDS - 1));
  assign rd_ctrl = r_hit && mem_axi_araddr[11:0] == 12'h000;
  assign rd_stat = r_hit && mem_axi_araddr[11:0] == 12'h004;
  assign rd_dig = r_hit && mem_axi_araddr[11:8] == 4'h2 && int'(r_idx) < DIGEST_WORDS;
  assign rd_msg = r_hit && mem_axi_araddr[11:8] == 4'h3 && int'(r_idx) < MSG_WORDS;
  assign rd_ok = rd_ctrl | rd_stat | rd_dig | rd_msg;
  assign rd_val = rd_ctrl ? {29'b0, auto_mode, irq_en, 1'b0} :
                  rd_stat ? {29'b0, err, done, state == RUN} :
                  rd_dig  ? dig[r_idx[DW-1:0]] :
                  rd_msg  ? msg[r_idx[MW-1:0]] : 32'b0;
  assign core_rst_o = state == IDLE;
  assign irq_o = done & irq_en;
  always_comb begin
    msg_o = '0;
    for (int i = 0; i < MSG_WORDS; i++) msg_o[MSG_WORDS*32-1-32*i -: 32] = msg[i];
  end
  always_comb begin
    state_nx = state;
    done_set = 1'b0;
    err_set = 1'b0;
    if (state == IDLE) state_nx = start_req ? RUN : IDLE;
    else if (core_ready_i) begin
      done_set = 1'b1;
      state_nx = IDLE;
    end else if (TIMEOUT_CYC != 0 && wd == TO_LAST) begin
      err_set = 1'b1;
      state_nx = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {mem_axi_awready, mem_axi_wready, mem_axi_bvalid, mem_axi_arready, mem_axi_rvalid} <= '0;
      {aw_full, w_full, irq_en, auto_mode, done, err} <= '0;
      mem_axi_bresp <= 2'b00;
      mem_axi_rresp <= 2'b00;
      mem_axi_rdata <= '0;
      aw_addr <= '0;
      w_data <= '0;
      w_strb <= '0;
      wd <= '0;
      for (int i = 0; i < MSG_WORDS; i++) msg[i] <= '0;
      for (int i = 0; i < DIGEST_WORDS; i++) dig[i] <= '0;
    end else begin
      mem_axi_awready <= mem_axi_awvalid & ~aw_full & ~mem_axi_awready & ~mem_axi_bvalid;
      mem_axi_wready <= mem_axi_wvalid & ~w_full & ~mem_axi_wready & ~mem_axi_bvalid;
      if (mem_axi_awvalid & mem_axi_awready) begin
        aw_full <= 1'b1;
        aw_addr <= mem_axi_awaddr;
      end
      if (mem_axi_wvalid & mem_axi_wready) begin
        w_full <= 1'b1;
        w_data <= mem_axi_wdata;
        w_strb <= mem_axi_wstrb;
      end
      if (wr_go) begin
        aw_full <= 1'b0;
        w_full <= 1'b0;
        mem_axi_bvalid <= 1'b1;
        mem_axi_bresp <= wr_ok ? 2'b00 : 2'b10;
      end else if (mem_axi_bready) mem_axi_bvalid <= 1'b0;
      if (wr_go & wr_ctrl & w_strb[0]) begin
        irq_en <= w_data[1];
        auto_mode <= w_data[2];
      end
      if (wr_go & wr_msg & state == IDLE)
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) msg[w_idx[MW-1:0]][8*b +: 8] <= w_data[8*b +: 8];
      done <= done_set | (done & ~(wr_go & wr_stat & w_data[1]));
      err <= err_set | (err & ~(wr_go & wr_stat & w_data[2]));
      if (done_set)
        for (int i = 0; i < DIGEST_WORDS; i++) dig[i] <= digest_i[DIGEST_WORDS*32-1-32*i -: 32];
      wd <= state == RUN ? wd + 32'd1 : 32'd0;
      mem_axi_arready <= mem_axi_arvalid & ~mem_axi_arready & ~mem_axi_rvalid;
      if (mem_axi_arvalid & mem_axi_arready) begin
        mem_axi_rvalid <= 1'b1;
        mem_axi_rdata <= rd_val;
        mem_axi_rresp <= rd_ok ? 2'b00 : 2'b10;
      end else if (mem_axi_rready) mem_axi_rvalid <= 1'b0;
    end
  end
endmodule
